// File: rtl/decoder_scan_pkg.sv
// Shared types and helpers for the decoder_scan_seq block.
// Optional feature macro used by the block: DECODER_SCAN_BLANK_EN.
package decoder_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_e;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Width of a counter that must hold values 0..dwell.
    function automatic int dwell_cnt_w(input int dwell);
        return $clog2(dwell + 1);
    endfunction

endpackage

// File: rtl/decoder_scan_seq_if.sv
// Control/select bus of decoder_scan_seq. The master drives enable, mode and
// the DIRECT-mode select handshake; the slave returns the decoded outputs.
interface decoder_scan_seq_if #(
    parameter int N = 2
);
    logic               en;
    logic               mode;
    logic               sel_valid;
    logic [N-1:0]       sel;
    logic               sel_ready;
    logic [2**N-1:0]    y;
    logic [N-1:0]       idx;
    logic               y_valid;
    logic               wrap;
    logic               sel_err;

    modport master (
        output en, mode, sel_valid, sel,
        input  sel_ready, y, idx, y_valid, wrap, sel_err
    );

    modport slave (
        input  en, mode, sel_valid, sel,
        output sel_ready, y, idx, y_valid, wrap, sel_err
    );
endinterface

// File: rtl/decoder_scan_seq_onehot_dec.sv
// Combinational binary-to-one-hot decoder with enable. The caller registers
// the result.
module onehot_dec #(
    parameter int N = 2
) (
    input  logic [N-1:0]    idx_i,
    input  logic            en_i,
    output logic [2**N-1:0] y_o
);
    localparam int OUTS = 2**N;

    // Single set bit at idx_i, or all zeros when disabled.
    always_comb begin
        y_o = en_i ? (OUTS'(1) << idx_i) : '0;
    end
endmodule

// File: rtl/decoder_scan_seq.sv
// Registered binary-to-one-hot decoder with DIRECT (handshaked select) and
// SCAN (auto-walk with dwell) modes.
// Optional feature macro: DECODER_SCAN_BLANK_EN inserts one blank cycle
// before every SCAN index change.
module decoder_scan_seq
    import decoder_scan_pkg::*;
#(
    parameter int N     = 2,
    parameter int LAST  = 2**N - 1,
    parameter int DWELL = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    decoder_scan_seq_if.slave  bus
);
    localparam int          OUTS     = 2**N;
    localparam int          W        = dwell_cnt_w(DWELL);
    localparam logic [N-1:0] LAST_IDX = N'(LAST);
    localparam logic [W-1:0] DWELL_END = W'(DWELL - 1);

    state_e            state_q, state_d;
    logic [N-1:0]      idx_q, idx_d;
    logic [W-1:0]      dwell_q, dwell_d;
    logic [OUTS-1:0]   y_q, y_d;
    logic              y_valid_q, y_valid_d;
    logic              sel_ready_q, sel_ready_d;
    logic              wrap_q, wrap_d;
    logic              sel_err_q, sel_err_d;
`ifdef DECODER_SCAN_BLANK_EN
    logic              blank_q, blank_d;
`endif

    logic [N-1:0]      dec_idx;
    logic              dec_en;
    logic [OUTS-1:0]   dec_y;
    logic              y_load;
    logic [N-1:0]      scan_nxt;
    logic              sel_bad;

    onehot_dec #(.N(N)) u_dec (
        .idx_i (dec_idx),
        .en_i  (dec_en),
        .y_o   (dec_y)
    );

    assign scan_nxt = (idx_q == LAST_IDX) ? '0 : idx_q + N'(1);
    assign sel_bad  = int'(bus.sel) > LAST;

    // Next-state and next-output selection for the IDLE/DIRECT/SCAN FSM.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        idx_d       = idx_q;
        dwell_d     = dwell_q;
        y_valid_d   = y_valid_q;
        sel_ready_d = 1'b0;
        wrap_d      = 1'b0;
        sel_err_d   = 1'b0;
        dec_idx     = idx_q;
        dec_en      = 1'b0;
        y_load      = 1'b0;
`ifdef DECODER_SCAN_BLANK_EN
        blank_d     = 1'b0;
`endif

        if (!bus.en) begin
            // Idle: outputs cleared, index held.
            state_d   = IDLE;
            y_load    = 1'b1;
            y_valid_d = 1'b0;
            dwell_d   = '0;
        end else if (bus.mode == MODE_DIRECT) begin
            state_d     = DIRECT;
            sel_ready_d = 1'b1;
            dwell_d     = '0;
            if (state_q != DIRECT) begin
                // Fresh entry into DIRECT: nothing decoded yet.
                y_load    = 1'b1;
                y_valid_d = 1'b0;
            end else if (bus.sel_valid && sel_ready_q) begin
                idx_d     = bus.sel;
                dec_idx   = bus.sel;
                dec_en    = !sel_bad;
                y_load    = 1'b1;
                y_valid_d = 1'b1;
                sel_err_d = sel_bad;
            end
        end else begin
            state_d = SCAN;
            if (state_q != SCAN) begin
                // Every SCAN entry restarts the walk at index 0.
                idx_d     = '0;
                dwell_d   = '0;
                dec_idx   = '0;
                dec_en    = 1'b1;
                y_load    = 1'b1;
                y_valid_d = 1'b1;
`ifdef DECODER_SCAN_BLANK_EN
            end else if (blank_q) begin
                // Leaving the blank: show the index loaded during the blank.
                // Index 0 is reachable only by wrapping.
                dec_en    = 1'b1;
                y_load    = 1'b1;
                y_valid_d = 1'b1;
                wrap_d    = (idx_q == '0);
                dwell_d   = '0;
            end else if (dwell_q == DWELL_END) begin
                idx_d     = scan_nxt;
                dwell_d   = '0;
                blank_d   = 1'b1;
                y_load    = 1'b1;
                y_valid_d = 1'b0;
`else
            end else if (dwell_q == DWELL_END) begin
                idx_d     = scan_nxt;
                dwell_d   = '0;
                dec_idx   = scan_nxt;
                dec_en    = 1'b1;
                y_load    = 1'b1;
                y_valid_d = 1'b1;
                wrap_d    = (idx_q == LAST_IDX);
`endif
            end else begin
                dwell_d = dwell_q + W'(1);
            end
        end
    end

    assign y_d = y_load ? dec_y : y_q;

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            dwell_q     <= '0;
            y_q         <= '0;
            y_valid_q   <= 1'b0;
            sel_ready_q <= 1'b0;
            wrap_q      <= 1'b0;
            sel_err_q   <= 1'b0;
`ifdef DECODER_SCAN_BLANK_EN
            blank_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dwell_q     <= dwell_d;
            y_q         <= y_d;
            y_valid_q   <= y_valid_d;
            sel_ready_q <= sel_ready_d;
            wrap_q      <= wrap_d;
            sel_err_q   <= sel_err_d;
`ifdef DECODER_SCAN_BLANK_EN
            blank_q     <= blank_d;
`endif
        end
    end

    assign bus.y         = y_q;
    assign bus.idx       = idx_q;
    assign bus.y_valid   = y_valid_q;
    assign bus.sel_ready = sel_ready_q;
    assign bus.wrap      = wrap_q;
    assign bus.sel_err   = sel_err_q;

endmodule
